// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver: captures LSB-first frames from an upstream
// serial source and buffers complete words in a first-word-fall-through FIFO.
module serial_word_rx #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic                          i_din,
  input  logic                          i_din_valid,
  output logic                          o_ready,
  output logic [DATA_WIDTH-1:0]         o_word,
  output logic                          o_word_valid,
  input  logic                          i_word_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic                   ready_d;
  logic                   push, pop, fifo_full;

  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q;

  // Space is reserved at frame start, so a push can never hit a full FIFO.
  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop       = i_word_ready && (count_q != '0);

  // NOTE: every signal assigned in this block gets a default first, so no path leaves it holding a value (no latch).
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ready_d   = o_ready;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_en && i_din_valid && !fifo_full) begin
          state_d   = SHIFT;
          ready_d   = 1'b1;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        // LSB arrives first and shifts down, ending up in bit 0.
        shift_d = {i_din, shift_q[DATA_WIDTH-1:1]};
        if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
          push    = 1'b1;
          ready_d = 1'b0;
          state_d = WAIT_LOW;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!i_din_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      o_ready   <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      o_ready   <= ready_d;
      o_busy    <= (state_d != IDLE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the output mux zeroes o_word while empty, so stale entries are never visible.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= shift_d;
  end

  assign o_word_valid = (count_q != '0);
  assign o_word       = o_word_valid ? mem[rd_ptr_q] : '0;
  assign o_fifo_count = count_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// Scoreboard bench for serial_word_rx: a serial-source model drives frames and
// queues expected words; a negedge monitor checks every word the DUT hands out.
module tb_serial_word_rx;

  localparam int W     = 24;
  localparam int DEPTH = 4;

  logic          tb_clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          din;
  logic          din_valid;
  logic          ready;
  logic [W-1:0]  word;
  logic          word_valid;
  logic          word_ready;
  logic [2:0]    fifo_count;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb [$];
  int  ready_run   = 0;
  int  ready_rises = 0;
  int  valid_run   = 0;
  bit  ready_prev  = 1'b0;
  bit  valid_prev  = 1'b0;

  always #5 tb_clk = ~tb_clk;

  serial_word_rx #(.DATA_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk        (tb_clk),
    .i_rst        (rst_n),
    .i_en         (en),
    .i_din        (din),
    .i_din_valid  (din_valid),
    .o_ready      (ready),
    .o_word       (word),
    .o_word_valid (word_valid),
    .i_word_ready (word_ready),
    .o_fifo_count (fifo_count),
    .o_busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: outputs are stable at the falling edge; a pop happens on the next rising edge.
  always @(negedge tb_clk) begin
    if (word_valid && word_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%h required=none", word);
      end else begin
        check("sb_word", {8'h0, word}, {8'h0, sb.pop_front()});
      end
    end
    check("valid_vs_count", {31'h0, word_valid}, {31'h0, fifo_count != 3'd0});
    if (ready && !ready_prev) begin
      ready_run = 1;
      ready_rises++;
    end else if (ready) begin
      ready_run++;
    end
    if (word_valid && !valid_prev) valid_run = 1;
    else if (word_valid) valid_run++;
    ready_prev = ready;
    valid_prev = word_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge tb_clk);
    #1;
  endtask

  // Serial-source model; abort_bit>=0 pulses reset while that bit is on the line.
  task automatic send_frame(input logic [W-1:0] w, input int abort_bit,
                            input bit hold_valid, input bit pop_last, input bit drop_en);
    int n = 0;
    din_valid = 1'b1;
    while (!ready && n < 300) begin
      tick(1);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", {31'h0, ready}, 32'h1);
      din_valid = 1'b0;
      return;
    end
    for (int k = 0; k < W; k++) begin
      din = w[k];
      if (drop_en && k == 5) en = 1'b0;
      if (pop_last && k == W - 1) word_ready = 1'b1;
      if (k == abort_bit) begin
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'h0, ready}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_count", {29'h0, fifo_count}, 32'h0);
        check("abort_valid", {31'h0, word_valid}, 32'h0);
        check("abort_word", {8'h0, word}, 32'h0);
        sb.delete();
        din_valid = 1'b0;
        din = 1'b0;
        tick(2);
        rst_n = 1'b1;
        return;
      end
      tick(1);
    end
    if (pop_last) word_ready = 1'b0;
    sb.push_back(w);
    check("frame_ready_low", {31'h0, ready}, 32'h0);
    check("frame_ready_len", ready_run, W);
    if (!hold_valid) begin
      din_valid = 1'b0;
      din = 1'b0;
      tick(1);
    end
  endtask

  task automatic drain();
    int n = 0;
    word_ready = 1'b1;
    while (fifo_count != 3'd0 && n < 50) begin
      tick(1);
      n++;
    end
    check("drain_count", {29'h0, fifo_count}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] wrap_vec [10];
    int rises0;
    wrap_vec = '{24'h000000, 24'hFFFFFF, 24'h5A5A5A, 24'hA5A5A5, 24'h123456,
                 24'h7FFFFF, 24'h800000, 24'h000100, 24'hC0FFEE, 24'h010203};

    rst_n = 1'b0; en = 1'b0; din = 1'b0; din_valid = 1'b0; word_ready = 1'b0;
    #1;
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_valid", {31'h0, word_valid}, 32'h0);
    check("rst_count", {29'h0, fifo_count}, 32'h0);
    check("rst_word", {8'h0, word}, 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Enable low blocks frame start.
    din_valid = 1'b1;
    tick(10);
    check("en_low_busy", {31'h0, busy}, 32'h0);
    check("en_low_ready", {31'h0, ready}, 32'h0);
    din_valid = 1'b0;
    en = 1'b1;
    tick(1);

    // Single frame with consumer always ready.
    word_ready = 1'b1;
    send_frame(24'h800001, -1, 1'b0, 1'b0, 1'b0);
    tick(3);
    check("single_valid_len", valid_run, 1);
    check("single_count", {29'h0, fifo_count}, 32'h0);

    // Backpressure: four frames fill the FIFO, the fifth waits for a pop.
    word_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(W'(i), -1, 1'b0, 1'b0, 1'b0);
    check("bp_full", {29'h0, fifo_count}, 32'h4);
    check("bp_head", {8'h0, word}, 32'h1);
    fork
      send_frame(24'h000005, -1, 1'b0, 1'b0, 1'b0);
      begin
        tick(40);
        check("bp_ready_blocked", {31'h0, ready}, 32'h0);
        check("bp_busy_blocked", {31'h0, busy}, 32'h0);
        check("bp_count_blocked", {29'h0, fifo_count}, 32'h4);
        word_ready = 1'b1;
        tick(1);
        word_ready = 1'b0;
      end
    join
    check("bp_count_after5", {29'h0, fifo_count}, 32'h4);
    drain();

    // Push and pop on the same edge with two entries held.
    word_ready = 1'b0;
    send_frame(24'h00AAAA, -1, 1'b0, 1'b0, 1'b0);
    send_frame(24'h00BBBB, -1, 1'b0, 1'b0, 1'b0);
    check("pp_count_before", {29'h0, fifo_count}, 32'h2);
    send_frame(24'h00CCCC, -1, 1'b0, 1'b1, 1'b0);
    check("pp_count_after", {29'h0, fifo_count}, 32'h2);
    check("pp_head", {8'h0, word}, 32'h00BBBB);
    drain();

    // Pointer wrap over ten frames.
    word_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_frame(wrap_vec[i], -1, 1'b0, 1'b0, 1'b0);
    tick(3);
    check("wrap_count", {29'h0, fifo_count}, 32'h0);

    // Valid held high after a frame blocks a second capture.
    send_frame(24'h3C3C3C, -1, 1'b1, 1'b0, 1'b0);
    rises0 = ready_rises;
    tick(30);
    check("hold_no_restart", ready_rises, rises0);
    check("hold_busy", {31'h0, busy}, 32'h1);
    din_valid = 1'b0;
    tick(1);
    check("hold_release_idle", {31'h0, busy}, 32'h0);
    send_frame(24'h0F0F0F, -1, 1'b0, 1'b0, 1'b0);

    // Enable dropping mid-frame completes the frame, then blocks the next one.
    send_frame(24'h765432, -1, 1'b0, 1'b0, 1'b1);
    din_valid = 1'b1;
    tick(10);
    check("en_drop_blocked", {31'h0, busy}, 32'h0);
    din_valid = 1'b0;
    en = 1'b1;
    tick(1);

    // Reset during bit 12 with one word already buffered.
    word_ready = 1'b0;
    send_frame(24'h123456, -1, 1'b0, 1'b0, 1'b0);
    check("pre_abort_count", {29'h0, fifo_count}, 32'h1);
    send_frame(24'h654321, 12, 1'b0, 1'b0, 1'b0);
    tick(2);
    check("post_abort_count", {29'h0, fifo_count}, 32'h0);
    word_ready = 1'b1;
    send_frame(24'hABCDEF, -1, 1'b0, 1'b0, 1'b0);
    tick(3);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_rx.md
SERIAL_WORD_RX -- requirements
Module: serial_word_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, bits per serial word and width of parallel output.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of output buffer entries; legal values are powers of two, 2 or greater.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_en  input  1  enables the start of new frames.
REQ-006 SHALL have port i_din  input  1  serial data from upstream FIR, LSB first.
REQ-007 SHALL have port i_din_valid  input  1  upstream has a word to send (FIR o_dout_valid).
REQ-008 SHALL have port o_ready  output  1  receiver is capturing bits (drives FIR i_ready).
REQ-009 SHALL have port o_word  output  DATA_WIDTH  FIFO head word, two's complement, bit 0 = first serial bit.
REQ-010 SHALL have port o_word_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port i_word_ready  input  1  consumer accepts o_word.
REQ-012 SHALL have port o_fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.
REQ-013 SHALL have port o_busy  output  1  state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, WAIT_LOW; o_ready and o_busy SHALL be registered.
REQ-015 IDLE -> SHIFT SHALL occur on the edge where i_en=1, i_din_valid=1 and o_fifo_count<FIFO_DEPTH; the same edge SHALL set o_ready=1 and bit counter=0.
REQ-016 With IDLE -> SHIFT on edge E0, bit k SHALL be sampled from i_din on edge E(k+1), k=0..DATA_WIDTH-1.
REQ-017 On edge E(DATA_WIDTH) the full word SHALL be pushed into the FIFO and o_ready SHALL clear; FSM SHALL go to WAIT_LOW.
REQ-018 WAIT_LOW SHALL return to IDLE on the first edge with i_din_valid=0; no new frame SHALL start while i_din_valid stays high.
REQ-019 i_en falling mid-frame SHALL NOT abort the frame; it SHALL only block the next IDLE -> SHIFT transition.
REQ-020 FIFO SHALL be first-word-fall-through: o_word = oldest entry; o_word_valid=1 exactly when o_fifo_count>0.
REQ-021 Pop SHALL occur on an edge with o_word_valid=1 and i_word_ready=1; i_word_ready with an empty FIFO SHALL be ignored.
REQ-022 Simultaneous push and pop SHALL leave o_fifo_count unchanged and preserve ordering.
REQ-023 A push into an empty FIFO SHALL make o_word_valid=1 and present the word after edge E(DATA_WIDTH): latency from last bit = 0 cycles.
REQ-024 Push SHALL never occur when full, because REQ-015 reserves space at frame start; pops during a frame only add space.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 Inputs are synchronous to i_clk; no CDC logic SHALL be included.

Reset
REQ-027 i_rst=0 SHALL immediately force IDLE, o_ready=0, o_busy=0, o_word_valid=0, o_fifo_count=0, o_word=0, counters and pointers=0, regardless of clock.
REQ-028 Reset mid-frame SHALL discard the partial word; no push SHALL occur for it.
REQ-029 After reset deasserts, the first frame SHALL start only per REQ-015.

Verification
REQ-030 Single frame: send 24'h800001 with i_word_ready=1 -> o_ready high for exactly 24 cycles, o_word=24'h800001 with o_word_valid high for 1 cycle.
REQ-031 Backpressure: i_word_ready=0, send 5 frames 24'h000001..24'h000005 -> 4 are captured, o_fifo_count=4, and o_ready stays low for frame 5 until one pop, then 24'h000005 is captured; pop order is 1..5.
REQ-032 Push and pop on the same edge with count=2 -> count stays 2 and order is preserved; the pointer wrap is exercised over at least 10 frames.
REQ-033 i_din_valid held high after a frame -> no second capture until it drops for at least 1 cycle.
REQ-034 Reset asserted at bit 12 of a frame -> o_ready=0 asynchronously, o_fifo_count=0, and the next full frame 24'hABCDEF is captured correctly.
REQ-035 End-to-end: FIR DUT driven with the 220-sample sine table -> 220 words received, each equal to the reference model output, with 0 mismatches.
